// File: rtl/rsv_station_param_if.sv
// Dispatch, CDB and issue bundle for the ALU reservation station.
// The station uses the slave view; the dispatch/CDB/ALU side uses master.
interface rsv_station_param_if #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int ROB_ID_W  = 4,
  parameter int CDB_PORTS = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                          disp_valid;
  logic [OP_W-1:0]               disp_op;
  logic [DATA_W-1:0]             disp_pc;
  logic [DATA_W-1:0]             disp_imm;
  logic [ROB_ID_W-1:0]           disp_rob_id;
  logic                          disp_rs1_rdy;
  logic                          disp_rs2_rdy;
  logic [DATA_W-1:0]             disp_rs1_val;
  logic [DATA_W-1:0]             disp_rs2_val;
  logic [ROB_ID_W-1:0]           disp_rs1_tag;
  logic [ROB_ID_W-1:0]           disp_rs2_tag;
  logic                          full;
  logic [CNT_W-1:0]              count;

  logic [CDB_PORTS-1:0]          cdb_valid;
  logic [CDB_PORTS*ROB_ID_W-1:0] cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0]   cdb_val;

  logic                          alu_valid;
  logic                          alu_ready;
  logic [OP_W-1:0]               alu_op;
  logic [DATA_W-1:0]             alu_pc;
  logic [DATA_W-1:0]             alu_rs1;
  logic [DATA_W-1:0]             alu_rs2;
  logic [DATA_W-1:0]             alu_imm;
  logic [ROB_ID_W-1:0]           alu_rob_id;

  modport master (
    output disp_valid, disp_op, disp_pc, disp_imm, disp_rob_id,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
           disp_rs1_tag, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_val, alu_ready,
    input  full, count,
           alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );

  modport slave (
    input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob_id,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
           disp_rs1_tag, disp_rs2_tag,
           cdb_valid, cdb_tag, cdb_val, alu_ready,
    output full, count,
           alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );
endinterface

// File: rtl/rsv_station_param.sv
// ALU reservation station: captures operands from dispatch or CDB, and issues
// the oldest ready entry (ROB order relative to rob_head) through an output register.
module rsv_station_param #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int ROB_ID_W  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                roll_back,
  input  logic [ROB_ID_W-1:0] rob_head,
  rsv_station_param_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]    ent_valid;
  logic [DEPTH-1:0]    ent_rs1_rdy;
  logic [DEPTH-1:0]    ent_rs2_rdy;
  logic [OP_W-1:0]     ent_op      [DEPTH];
  logic [DATA_W-1:0]   ent_pc      [DEPTH];
  logic [DATA_W-1:0]   ent_imm     [DEPTH];
  logic [ROB_ID_W-1:0] ent_rob_id  [DEPTH];
  logic [DATA_W-1:0]   ent_rs1_val [DEPTH];
  logic [DATA_W-1:0]   ent_rs2_val [DEPTH];
  logic [ROB_ID_W-1:0] ent_rs1_tag [DEPTH];
  logic [ROB_ID_W-1:0] ent_rs2_tag [DEPTH];
  logic [ROB_ID_W-1:0] ent_dist    [DEPTH];

  // Snoop results are {hit, value}.
  logic [DATA_W:0]     rs1_snp [DEPTH];
  logic [DATA_W:0]     rs2_snp [DEPTH];
  logic [DATA_W:0]     disp1_snp;
  logic [DATA_W:0]     disp2_snp;

  logic [CNT_W-1:0]    count_q;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic [ROB_ID_W-1:0] sel_dist;
  logic                sel_found;
  logic                accept;
  logic                load_ok;
  logic                issue;

  // Scanning from the highest port down lets the lowest matching port win.
  function automatic logic [DATA_W:0] snoop(
    input logic [ROB_ID_W-1:0]           tag,
    input logic [CDB_PORTS-1:0]          vld,
    input logic [CDB_PORTS*ROB_ID_W-1:0] tags,
    input logic [CDB_PORTS*DATA_W-1:0]   vals
  );
    snoop = '0;
    for (int k = CDB_PORTS - 1; k >= 0; k--)
      if (vld[k] && tags[k*ROB_ID_W +: ROB_ID_W] == tag)
        snoop = {1'b1, vals[k*DATA_W +: DATA_W]};
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    disp1_snp = snoop(bus.disp_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    disp2_snp = snoop(bus.disp_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    for (int i = 0; i < DEPTH; i++) begin
      rs1_snp[i]  = snoop(ent_rs1_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      rs2_snp[i]  = snoop(ent_rs2_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      ent_dist[i] = ent_rob_id[i] - rob_head;
    end
  end

  // Oldest ready entry; strict compare keeps the lowest index on ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_dist  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rs1_rdy[i] && ent_rs2_rdy[i] &&
          (!sel_found || ent_dist[i] < sel_dist)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_dist  = ent_dist[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_valid[i]) free_idx = IDX_W'(i);
  end

  assign bus.full  = (count_q == CNT_W'(DEPTH));
  assign bus.count = count_q;
  assign accept    = bus.disp_valid && !bus.full;
  assign load_ok   = !bus.alu_valid || bus.alu_ready;
  assign issue     = load_ok && sel_found;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || roll_back) begin
      ent_valid      <= '0;
      count_q        <= '0;
      bus.alu_valid  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_pc     <= '0;
      bus.alu_rs1    <= '0;
      bus.alu_rs2    <= '0;
      bus.alu_imm    <= '0;
      bus.alu_rob_id <= '0;
    end else if (rdy) begin
      // The issued entry is still valid here, so free_idx never points at it.
      if (issue)  ent_valid[sel_idx]  <= 1'b0;
      if (accept) ent_valid[free_idx] <= 1'b1;
      count_q <= count_q + CNT_W'(accept) - CNT_W'(issue);
      if (load_ok) begin
        bus.alu_valid <= sel_found;
        if (sel_found) begin
          bus.alu_op     <= ent_op[sel_idx];
          bus.alu_pc     <= ent_pc[sel_idx];
          bus.alu_rs1    <= ent_rs1_val[sel_idx];
          bus.alu_rs2    <= ent_rs2_val[sel_idx];
          bus.alu_imm    <= ent_imm[sel_idx];
          bus.alu_rob_id <= ent_rob_id[sel_idx];
        end
      end
    end
  end

  // NOTE: entry payload storage has no reset; ent_valid alone decides whether
  // an entry's contents mean anything, which keeps the arrays as plain storage.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && !ent_rs1_rdy[i] && rs1_snp[i][DATA_W]) begin
          ent_rs1_rdy[i] <= 1'b1;
          ent_rs1_val[i] <= rs1_snp[i][DATA_W-1:0];
        end
        if (ent_valid[i] && !ent_rs2_rdy[i] && rs2_snp[i][DATA_W]) begin
          ent_rs2_rdy[i] <= 1'b1;
          ent_rs2_val[i] <= rs2_snp[i][DATA_W-1:0];
        end
      end
      if (accept) begin
        ent_op[free_idx]      <= bus.disp_op;
        ent_pc[free_idx]      <= bus.disp_pc;
        ent_imm[free_idx]     <= bus.disp_imm;
        ent_rob_id[free_idx]  <= bus.disp_rob_id;
        ent_rs1_tag[free_idx] <= bus.disp_rs1_tag;
        ent_rs2_tag[free_idx] <= bus.disp_rs2_tag;
        ent_rs1_rdy[free_idx] <= bus.disp_rs1_rdy || disp1_snp[DATA_W];
        ent_rs2_rdy[free_idx] <= bus.disp_rs2_rdy || disp2_snp[DATA_W];
        ent_rs1_val[free_idx] <= bus.disp_rs1_rdy ? bus.disp_rs1_val : disp1_snp[DATA_W-1:0];
        ent_rs2_val[free_idx] <= bus.disp_rs2_rdy ? bus.disp_rs2_val : disp2_snp[DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_rsv_station_param.sv
// Directed and random bench for rsv_station_param against a queue-based
// model of waiting instructions that picks the oldest ready one by ROB age.
module tb_rsv_station_param;
  localparam int DEPTH = 16, DATA_W = 32, OP_W = 6, RW = 4, CP = 2;

  logic          clk = 1'b0;
  logic          rst, rdy, roll_back;
  logic [RW-1:0] rob_head;

  rsv_station_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W),
                         .ROB_ID_W(RW), .CDB_PORTS(CP)) bif ();

  rsv_station_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W),
                      .ROB_ID_W(RW), .CDB_PORTS(CP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .roll_back(roll_back),
    .rob_head(rob_head), .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc, imm;
    logic [RW-1:0]     rob;
    bit                ok1, ok2;
    logic [DATA_W-1:0] v1, v2;
    logic [RW-1:0]     t1, t2;
  } instr_t;

  instr_t q[$];
  bit     m_valid;
  instr_t m_out;
  int     checks = 0;
  int     fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bcast(input logic [RW-1:0] t, output logic [DATA_W-1:0] v);
    v = '0;
    for (int k = 0; k < CP; k++)
      if (bif.cdb_valid[k] && bif.cdb_tag[k*RW +: RW] == t) begin
        v = bif.cdb_val[k*DATA_W +: DATA_W];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] age(input logic [RW-1:0] r);
    return r - rob_head;
  endfunction

  function automatic bit in_q(input logic [RW-1:0] r);
    foreach (q[i]) if (q[i].rob == r) return 1'b1;
    return 1'b0;
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int                sel;
    bit                was_full;
    instr_t            n;
    logic [DATA_W-1:0] v;
    if (rst || roll_back) begin
      q.delete();
      m_valid = 1'b0;
      m_out   = '{default: 0};
      return;
    end
    if (!rdy) return;
    sel = -1;
    foreach (q[i])
      if (q[i].ok1 && q[i].ok2 && (sel < 0 || age(q[i].rob) < age(q[sel].rob))) sel = i;
    was_full = (q.size() == DEPTH);
    foreach (q[i]) begin
      n = q[i];
      if (!n.ok1 && bcast(n.t1, v)) begin n.ok1 = 1'b1; n.v1 = v; end
      if (!n.ok2 && bcast(n.t2, v)) begin n.ok2 = 1'b1; n.v2 = v; end
      q[i] = n;
    end
    if (!m_valid || bif.alu_ready) begin
      m_valid = (sel >= 0);
      if (sel >= 0) begin
        m_out = q[sel];
        q.delete(sel);
      end
    end
    if (bif.disp_valid && !was_full) begin
      n.op  = bif.disp_op;   n.pc  = bif.disp_pc;  n.imm = bif.disp_imm;
      n.rob = bif.disp_rob_id;
      n.ok1 = bif.disp_rs1_rdy; n.v1 = bif.disp_rs1_val; n.t1 = bif.disp_rs1_tag;
      n.ok2 = bif.disp_rs2_rdy; n.v2 = bif.disp_rs2_val; n.t2 = bif.disp_rs2_tag;
      if (!n.ok1 && bcast(n.t1, v)) begin n.ok1 = 1'b1; n.v1 = v; end
      if (!n.ok2 && bcast(n.t2, v)) begin n.ok2 = 1'b1; n.v2 = v; end
      q.push_back(n);
    end
  endtask

  task automatic compare(input string w);
    check({w, "_valid"}, bif.alu_valid, m_valid);
    check({w, "_count"}, bif.count, q.size());
    check({w, "_full"},  bif.full, q.size() == DEPTH);
    if (m_valid) begin
      check({w, "_op"},  bif.alu_op,     m_out.op);
      check({w, "_pc"},  bif.alu_pc,     m_out.pc);
      check({w, "_imm"}, bif.alu_imm,    m_out.imm);
      check({w, "_rob"}, bif.alu_rob_id, m_out.rob);
      check({w, "_rs1"}, bif.alu_rs1,    m_out.v1);
      check({w, "_rs2"}, bif.alu_rs2,    m_out.v2);
    end
  endtask

  task automatic tick(input string w);
    model_step();
    @(posedge clk);
    #1;
    compare(w);
  endtask

  task automatic idle();
    bif.disp_valid = 1'b0;
    bif.cdb_valid  = '0;
  endtask

  task automatic set_disp(input logic [RW-1:0] rob, input logic [OP_W-1:0] op,
                          input bit ok1, input logic [DATA_W-1:0] v1, input logic [RW-1:0] t1,
                          input bit ok2, input logic [DATA_W-1:0] v2, input logic [RW-1:0] t2);
    bif.disp_valid   = 1'b1;
    bif.disp_rob_id  = rob;
    bif.disp_op      = op;
    bif.disp_pc      = 32'h1000 + 32'(rob) * 4;
    bif.disp_imm     = 32'(op) * 3 + 32'h7;
    bif.disp_rs1_rdy = ok1; bif.disp_rs1_val = v1; bif.disp_rs1_tag = t1;
    bif.disp_rs2_rdy = ok2; bif.disp_rs2_val = v2; bif.disp_rs2_tag = t2;
  endtask

  task automatic set_cdb(input int port, input logic [RW-1:0] tag, input logic [DATA_W-1:0] val);
    bif.cdb_valid[port]             = 1'b1;
    bif.cdb_tag[port*RW +: RW]      = tag;
    bif.cdb_val[port*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    logic [RW-1:0] r;
    rst = 1'b1; rdy = 1'b1; roll_back = 1'b0; rob_head = '0;
    bif.cdb_tag = '0; bif.cdb_val = '0; bif.alu_ready = 1'b1;
    set_disp(0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    idle();
    tick("rst"); tick("rst");
    check("rst_alu_valid", bif.alu_valid, 0);
    check("rst_count", bif.count, 0);
    check("rst_full", bif.full, 0);
    check("rst_alu_rs1", bif.alu_rs1, 0);
    check("rst_alu_rob", bif.alu_rob_id, 0);
    rst = 1'b0;

    // Both operands ready: issue two edges after dispatch.
    set_disp(5, 3, 1'b1, 32'h10, 0, 1'b1, 32'h20, 0);
    tick("t1"); idle();
    check("t1_count_after_disp", bif.count, 1);
    check("t1_not_yet_valid", bif.alu_valid, 0);
    tick("t1");
    check("t1_alu_valid", bif.alu_valid, 1);
    check("t1_alu_rs1", bif.alu_rs1, 32'h10);
    check("t1_alu_rs2", bif.alu_rs2, 32'h20);
    check("t1_alu_rob", bif.alu_rob_id, 5);
    check("t1_alu_op", bif.alu_op, 3);
    check("t1_count_zero", bif.count, 0);
    tick("t1");

    // CDB wakeup three cycles after dispatch, then same-cycle bypass.
    set_disp(2, 4, 1'b0, 0, 7, 1'b1, 32'h99, 0);
    tick("t2"); idle(); tick("t2"); tick("t2");
    set_cdb(1, 7, 32'hABCD);
    tick("t2"); idle();
    check("t2_wake_not_valid", bif.alu_valid, 0);
    tick("t2");
    check("t2_wake_valid", bif.alu_valid, 1);
    check("t2_wake_rs1", bif.alu_rs1, 32'hABCD);
    check("t2_wake_rob", bif.alu_rob_id, 2);
    tick("t2");
    set_disp(3, 5, 1'b0, 0, 8, 1'b1, 32'h77, 0);
    set_cdb(0, 8, 32'h1234);
    tick("t2b"); idle(); tick("t2b");
    check("t2_bypass_valid", bif.alu_valid, 1);
    check("t2_bypass_rs1", bif.alu_rs1, 32'h1234);
    check("t2_bypass_rob", bif.alu_rob_id, 3);
    tick("t2b");

    // Age order across the ROB wrap: rob 15 is older than rob 1 with head 14.
    rob_head = 14;
    set_disp(1,  1, 1'b0, 0, 12, 1'b1, 32'h1, 0); tick("t3");
    set_disp(4,  2, 1'b0, 0, 13, 1'b1, 32'h2, 0); tick("t3");
    set_disp(5,  3, 1'b0, 0, 13, 1'b1, 32'h3, 0); tick("t3");
    set_disp(15, 4, 1'b0, 0, 12, 1'b1, 32'h4, 0); tick("t3");
    idle();
    set_cdb(0, 12, 32'h55);
    tick("t3"); idle(); tick("t3");
    check("t3_first_rob", bif.alu_rob_id, 15);
    tick("t3");
    check("t3_second_rob", bif.alu_rob_id, 1);
    set_cdb(0, 13, 32'h66);
    tick("t3"); idle(); tick("t3"); tick("t3"); tick("t3");

    // Fill all entries, drop an extra dispatch, wake one and watch full drop.
    rob_head = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(RW'(i), OP_W'(i), 1'b0, 0, RW'(i + 1), 1'b1, 32'(i), 0);
      tick("t4");
    end
    check("t4_full", bif.full, 1);
    check("t4_count16", bif.count, 16);
    set_disp(0, 9, 1'b1, 32'h5, 0, 1'b1, 32'h6, 0);
    tick("t4"); idle();
    check("t4_drop_count", bif.count, 16);
    set_cdb(0, 1, 32'hBEEF);
    tick("t4"); idle();
    check("t4_still_full", bif.full, 1);
    tick("t4");
    check("t4_issue_rob", bif.alu_rob_id, 0);
    check("t4_issue_rs1", bif.alu_rs1, 32'hBEEF);
    check("t4_full_drops", bif.full, 0);
    check("t4_count15", bif.count, 15);
    roll_back = 1'b1; tick("t4"); roll_back = 1'b0;

    // Back-pressure: payload holds while alu_ready is low.
    bif.alu_ready = 1'b0;
    set_disp(3, 10, 1'b1, 32'h31, 0, 1'b1, 32'h32, 0); tick("t5");
    set_disp(4, 11, 1'b1, 32'h41, 0, 1'b1, 32'h42, 0); tick("t5");
    set_disp(5, 12, 1'b1, 32'h51, 0, 1'b1, 32'h52, 0); tick("t5");
    idle();
    for (int i = 0; i < 4; i++) begin
      tick("t5");
      check("t5_hold_rob", bif.alu_rob_id, 3);
      check("t5_hold_count", bif.count, 2);
    end
    bif.alu_ready = 1'b1;
    tick("t5"); check("t5_next_rob4", bif.alu_rob_id, 4);
    tick("t5"); check("t5_next_rob5", bif.alu_rob_id, 5);
    tick("t5"); check("t5_drained", bif.alu_valid, 0);

    // Rollback with five waiting entries and a held output.
    bif.alu_ready = 1'b0;
    set_disp(6, 1, 1'b1, 32'h61, 0, 1'b1, 32'h62, 0); tick("t6");
    for (int i = 7; i < 12; i++) begin
      set_disp(RW'(i), 2, 1'b0, 0, 14, 1'b1, 32'h0, 0);
      tick("t6");
    end
    idle();
    check("t6_pre_count", bif.count, 5);
    check("t6_pre_valid", bif.alu_valid, 1);
    roll_back = 1'b1; tick("t6"); roll_back = 1'b0;
    check("t6_count", bif.count, 0);
    check("t6_valid", bif.alu_valid, 0);
    check("t6_full", bif.full, 0);
    bif.alu_ready = 1'b1;
    set_cdb(0, 14, 32'h1);
    tick("t6"); idle(); tick("t6");
    check("t6_no_ghost_issue", bif.alu_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      roll_back     = ($urandom_range(0, 199) == 0);
      rob_head      = RW'($urandom);
      bif.alu_ready = ($urandom_range(0, 3) != 0);
      r = RW'($urandom);
      while (q.size() < DEPTH && in_q(r)) r = RW'($urandom);
      set_disp(r, OP_W'($urandom), $urandom_range(0, 2) == 0, $urandom, RW'($urandom),
               $urandom_range(0, 2) == 0, $urandom, RW'($urandom));
      bif.disp_valid = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      bif.cdb_valid  = '0;
      for (int k = 0; k < CP; k++)
        if ($urandom_range(0, 1) != 0) begin
          if (q.size() > 0 && $urandom_range(0, 1) != 0)
            set_cdb(k, q[$urandom_range(0, q.size() - 1)].t1, $urandom);
          else
            set_cdb(k, RW'($urandom), $urandom);
        end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
